rom_ioctl_loader: RTL and testbench
===================================

// Module: rom_ioctl_loader
// PURPOSE
//  Upstream feeder for the cart-detect top: turns a byte stream (ROM image pushed by the
//  sim harness) into MiSTer-style ioctl download cycles (ioctl_download/wr/addr/dout/index).
//  Paces write strobes, honours ioctl_wait and frames the download, so detect2600 sees
//  hps_io-like traffic. Its falling ioctl_download triggers the downstream bs/done latch.
// PARAMETERS
//  ADDR_W     25       width of ioctl_addr
//  WR_GAP     1        idle cycles after each ioctl_wr pulse (0 = none)
//  MAX_BYTES  65536    max bytes written; must be <= 2**ADDR_W
// PORTS
//  clk_sys         in   1       system clock; all logic on posedge
//  reset           in   1       synchronous, active-high reset
//  start           in   1       1-cycle request to begin a download; ignored while busy
//  index_in        in   8       file index, captured on accepted start
//  src_valid       in   1       source byte valid
//  src_data        in   8       source byte
//  src_last        in   1       marks final byte of the image (qualified by src_valid)
//  src_ready       out  1       byte accepted when src_valid & src_ready
//  ioctl_download  out  1       download window
//  ioctl_index     out  8       captured index_in
//  ioctl_wr        out  1       1-cycle write strobe
//  ioctl_addr      out  ADDR_W  byte address of current write
//  ioctl_dout      out  8       write data
//  ioctl_wait      in   1       consumer stall
//  busy            out  1       high from accepted start until return to IDLE
//  done            out  1       1-cycle pulse at end of download
//  overflow        out  1       sticky: image exceeded MAX_BYTES; cleared on next start
//  byte_count      out  32      bytes written (== last ioctl_addr+1); held until next start
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE; reset mid-download drops ioctl_download the next edge,
//   no done pulse.
//  FSM: IDLE -> ARM -> FETCH -> WRITE -> [GAP] -> FETCH ... -> TAIL -> FINISH -> IDLE.
//  IDLE: start=1 -> ARM; captures index, clears byte_count/overflow/addr. busy=1 from ARM on.
//  ARM (1 cyc): ioctl_download=1, no strobe. ioctl_download stays 1 through TAIL.
//  FETCH: src_ready=1; on src_valid latch data/last into ioctl_dout -> WRITE.
//   If byte_count==MAX_BYTES: byte discarded, overflow=1, stay FETCH until src_last -> TAIL.
//  WRITE: if ioctl_wait=0: ioctl_wr=1 for this cycle, ioctl_addr=byte_count[ADDR_W-1:0],
//   byte_count+1 next edge; then GAP if WR_GAP>0 else FETCH; if byte was last -> TAIL.
//   If ioctl_wait=1: ioctl_wr=0, addr/dout held, stay WRITE.
//  GAP: WR_GAP cycles, ioctl_wr=0, src_ready=0; ioctl_wait ignored; -> FETCH.
//  TAIL (1 cyc): download=1, wr=0. FINISH: download=0, done=1 one cycle, busy=0 next -> IDLE.
//  ioctl_addr holds last written address after the download; ioctl_wr never back-to-back
//   when WR_GAP>0. src_ready=0 outside FETCH. start while busy: no effect.
//  Throughput, no stalls: one byte per 2+WR_GAP cycles.
//  start->first ioctl_wr: 3 cycles min (ARM, FETCH, WRITE).
// TESTING
//  4-byte image 11,22,33,44 (last on 44), WR_GAP=1, no wait -> wr at addr 0..3 data
//   11..44 every 3 cycles; download falls 2 cycles after last wr; done 1 pulse; byte_count=4.
//  Same image, ioctl_wait=1 for 5 cycles during byte 2 -> no wr while wait high;
//   addr=1/dout=22 held; 22 written once after release; total 4 wr strobes.
//  MAX_BYTES=4, 6-byte image -> 4 writes (addr 0..3), bytes 5-6 accepted and dropped;
//   overflow=1, byte_count=4, done pulses.
//  Single byte with src_last=1, data A5 -> one wr at addr 0; byte_count=1.
//   Pulse start again while busy -> ignored.
//  Assert reset after 2 writes of an 8-byte image -> next cycle download=0, wr=0, busy=0,
//   no done; fresh start then loads from addr 0 with byte_count restarting at 0.
//  WR_GAP=0, src_valid held high, 3 bytes -> wr strobes 2 cycles apart; addr 0,1,2.

Source files
------------

// File: rtl/rom_ioctl_loader.sv
// rom_ioctl_loader: turns a valid/ready byte stream (a ROM image) into
// MiSTer hps_io-style ioctl download cycles for the cart-detect logic.
//
// Ports
//   clk_sys, reset        clock, synchronous active-high reset
//   start, index_in       begin a download (ignored while busy), file index
//   src_valid/data/last   source byte stream; src_ready accepts a byte
//   ioctl_download/index  download window and captured index
//   ioctl_wr/addr/dout    one-cycle write strobe, byte address, data
//   ioctl_wait            consumer stall, honoured while a write is pending
//   busy, done            in-progress flag, one-cycle end-of-download pulse
//   overflow              sticky: image longer than MAX_BYTES
//   byte_count            bytes written so far / in the last download
module rom_ioctl_loader #(
  parameter int unsigned ADDR_W    = 25,
  parameter int unsigned WR_GAP    = 1,
  parameter int unsigned MAX_BYTES = 65536
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        index_in,
  input  logic              src_valid,
  input  logic [7:0]        src_data,
  input  logic              src_last,
  output logic              src_ready,
  output logic              ioctl_download,
  output logic [7:0]        ioctl_index,
  output logic              ioctl_wr,
  output logic [ADDR_W-1:0] ioctl_addr,
  output logic [7:0]        ioctl_dout,
  input  logic              ioctl_wait,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [31:0]       byte_count
);

  localparam int unsigned GAP_W = (WR_GAP > 1) ? $clog2(WR_GAP) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_FETCH, S_WRITE, S_GAP, S_TAIL, S_FINISH
  } state_t;

  state_t           state, state_nxt;
  logic [GAP_W-1:0] gap_cnt;
  logic             last_q;
  logic             full;

  // Once MAX_BYTES have been written, further bytes are drained and dropped.
  assign full = (byte_count == 32'(MAX_BYTES));

  // State register
  always_ff @(posedge clk_sys) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state and state-decoded handshake/strobe outputs
  always_comb begin
    state_nxt      = state;
    src_ready      = 1'b0;
    ioctl_download = 1'b0;
    ioctl_wr       = 1'b0;
    busy           = 1'b1;
    done           = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = S_ARM;
      end
      S_ARM: begin
        ioctl_download = 1'b1;
        state_nxt      = S_FETCH;
      end
      S_FETCH: begin
        ioctl_download = 1'b1;
        src_ready      = 1'b1;
        if (src_valid) begin
          if (!full)         state_nxt = S_WRITE;
          else if (src_last) state_nxt = S_TAIL;
        end
      end
      S_WRITE: begin
        ioctl_download = 1'b1;
        if (!ioctl_wait) begin
          ioctl_wr = 1'b1;
          if (last_q)          state_nxt = S_TAIL;
          else if (WR_GAP > 0) state_nxt = S_GAP;
          else                 state_nxt = S_FETCH;
        end
      end
      S_GAP: begin
        ioctl_download = 1'b1;
        if (gap_cnt == GAP_W'(WR_GAP - 1)) state_nxt = S_FETCH;
      end
      S_TAIL: begin
        ioctl_download = 1'b1;
        state_nxt      = S_FINISH;
      end
      S_FINISH: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath: captured index, write data/address, counters and flags
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      ioctl_index <= '0;
      ioctl_addr  <= '0;
      ioctl_dout  <= '0;
      byte_count  <= '0;
      overflow    <= 1'b0;
      last_q      <= 1'b0;
      gap_cnt     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            ioctl_index <= index_in;
            ioctl_addr  <= '0;
            byte_count  <= '0;
            overflow    <= 1'b0;
          end
        end
        S_FETCH: begin
          if (src_valid) begin
            if (full) begin
              overflow <= 1'b1;
            end else begin
              ioctl_dout <= src_data;
              last_q     <= src_last;
              // Address of the pending write; held afterwards as the last written address.
              ioctl_addr <= ADDR_W'(byte_count);
            end
          end
        end
        S_WRITE: begin
          gap_cnt <= '0;
          if (!ioctl_wait) byte_count <= byte_count + 32'd1;
        end
        S_GAP: gap_cnt <= gap_cnt + GAP_W'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_ioctl_loader.sv
// Directed bench for rom_ioctl_loader: three instances cover WR_GAP=1,
// MAX_BYTES=4 and WR_GAP=0; a negedge monitor logs the selected instance's writes.
module tb_rom_ioctl_loader;

  logic        clk;
  logic        reset;
  logic [2:0]  start_v;
  logic [7:0]  index_in;
  logic        src_valid;
  logic [7:0]  src_data;
  logic        src_last;
  logic        ioctl_wait;

  logic [2:0]        ready_v, dl_v, wr_v, busy_v, done_v, ovf_v;
  logic [2:0][7:0]   idx_v, dout_v;
  logic [2:0][24:0]  addr_v;
  logic [2:0][31:0]  bc_v;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    rom_ioctl_loader #(
      .ADDR_W   (25),
      .WR_GAP   ((g == 2) ? 0 : 1),
      .MAX_BYTES((g == 1) ? 4 : 65536)
    ) u_dut (
      .clk_sys       (clk),
      .reset         (reset),
      .start         (start_v[g]),
      .index_in      (index_in),
      .src_valid     (src_valid),
      .src_data      (src_data),
      .src_last      (src_last),
      .src_ready     (ready_v[g]),
      .ioctl_download(dl_v[g]),
      .ioctl_index   (idx_v[g]),
      .ioctl_wr      (wr_v[g]),
      .ioctl_addr    (addr_v[g]),
      .ioctl_dout    (dout_v[g]),
      .ioctl_wait    (ioctl_wait),
      .busy          (busy_v[g]),
      .done          (done_v[g]),
      .overflow      (ovf_v[g]),
      .byte_count    (bc_v[g])
    );
  end

  typedef struct {
    logic [24:0] a;
    logic [7:0]  d;
    int          c;
  } wr_t;

  wr_t        wr_q[$];
  logic [7:0] img[$];
  logic [7:0] exp_d[$];
  int         sel = 0;
  int         cyc = 0;
  int         start_cyc = 0;
  int         done_cnt = 0;
  int         done_cyc = -1;
  int         fall_cyc = -1;
  logic       dl_prev = 1'b0;
  int         n_chk = 0;
  int         n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Log writes, done pulses and the falling edge of the download window
  always @(negedge clk) begin
    if (wr_v[sel]) wr_q.push_back('{addr_v[sel], dout_v[sel], cyc});
    if (done_v[sel]) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
    if (dl_prev && !dl_v[sel]) fall_cyc = cyc;
    dl_prev = dl_v[sel];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (got !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Called at a negedge; returns at the negedge after the byte was accepted.
  task automatic push(input logic [7:0] d, input logic l);
    int w;
    w = 0;
    src_valid = 1'b1;
    src_data  = d;
    src_last  = l;
    while (!ready_v[sel] && w < 40) begin
      @(negedge clk);
      w++;
    end
    check("push_ready", 32'(ready_v[sel]), 32'd1);
    @(negedge clk);
  endtask

  task automatic load(input int s, input logic [7:0] idx);
    sel = s;
    wr_q.delete();
    done_cnt = 0;
    done_cyc = -1;
    fall_cyc = -1;
    start_v[s] = 1'b1;
    index_in   = idx;
    start_cyc  = cyc;
    @(negedge clk);
    start_v = '0;
  endtask

  task automatic send_image();
    for (int i = 0; i < img.size(); i++) push(img[i], (i == img.size() - 1));
    src_valid = 1'b0;
    src_last  = 1'b0;
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    while (busy_v[sel] && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("idle_reached", 32'(busy_v[sel]), 32'd0);
  endtask

  task automatic check_log(input int gap);
    check("wr_count", 32'(wr_q.size()), 32'(exp_d.size()));
    for (int i = 0; i < wr_q.size() && i < exp_d.size(); i++) begin
      check("wr_addr", 32'(wr_q[i].a), 32'(i));
      check("wr_data", 32'(wr_q[i].d), 32'(exp_d[i]));
      if (gap > 0 && i > 0) check("wr_spacing", 32'(wr_q[i].c - wr_q[i-1].c), 32'(gap));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; start_v = '0; index_in = '0; src_valid = 1'b0;
    src_data = '0; src_last = 1'b0; ioctl_wait = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_download", 32'(dl_v[0]), 32'd0);
    check("rst_wr", 32'(wr_v[0]), 32'd0);
    check("rst_busy", 32'(busy_v[0]), 32'd0);
    check("rst_ready", 32'(ready_v[0]), 32'd0);
    check("rst_count", bc_v[0], 32'd0);
    check("rst_overflow", 32'(ovf_v[0]), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Basic 4-byte image, WR_GAP=1
    img   = '{8'h11, 8'h22, 8'h33, 8'h44};
    exp_d = '{8'h11, 8'h22, 8'h33, 8'h44};
    load(0, 8'h03);
    send_image();
    wait_idle();
    check_log(3);
    if (wr_q.size() == 4) begin
      check("first_wr_latency", 32'(wr_q[0].c - start_cyc), 32'd3);
      check("download_fall", 32'(fall_cyc - wr_q[3].c), 32'd2);
    end
    check("done_pulses", 32'(done_cnt), 32'd1);
    check("done_at_fall", 32'(done_cyc), 32'(fall_cyc));
    check("byte_count4", bc_v[0], 32'd4);
    check("index", 32'(idx_v[0]), 32'h03);
    check("addr_held", 32'(addr_v[0]), 32'd3);
    check("no_overflow", 32'(ovf_v[0]), 32'd0);

    // Same image with ioctl_wait high for 5 cycles over byte 2
    load(0, 8'h04);
    fork
      send_image();
      begin
        int w;
        w = 0;
        while (!(wr_q.size() == 1 && ready_v[0]) && w < 50) begin
          @(negedge clk);
          w++;
        end
        check("stall_sync", 32'(wr_q.size()), 32'd1);
        @(posedge clk);
        #1 ioctl_wait = 1'b1;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          check("stall_wr", 32'(wr_v[0]), 32'd0);
          check("stall_addr", 32'(addr_v[0]), 32'd1);
          check("stall_dout", 32'(dout_v[0]), 32'h22);
        end
        @(posedge clk);
        #1 ioctl_wait = 1'b0;
      end
    join
    wait_idle();
    check_log(0);
    check("stall_done", 32'(done_cnt), 32'd1);
    check("stall_count", bc_v[0], 32'd4);

    // Overflow: MAX_BYTES=4, 6-byte image
    img   = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    exp_d = '{8'h01, 8'h02, 8'h03, 8'h04};
    load(1, 8'h01);
    send_image();
    wait_idle();
    check_log(3);
    check("ovf_flag", 32'(ovf_v[1]), 32'd1);
    check("ovf_count", bc_v[1], 32'd4);
    check("ovf_done", 32'(done_cnt), 32'd1);
    check("ovf_addr_held", 32'(addr_v[1]), 32'd3);
    img   = '{8'h99};
    exp_d = '{8'h99};
    load(1, 8'h02);
    send_image();
    wait_idle();
    check("ovf_cleared", 32'(ovf_v[1]), 32'd0);
    check("ovf_restart_count", bc_v[1], 32'd1);

    // Single byte, plus a start pulse while busy
    exp_d = '{8'hA5};
    load(0, 8'h42);
    start_v[0] = 1'b1;
    index_in   = 8'h77;
    @(negedge clk);
    start_v = '0;
    push(8'hA5, 1'b1);
    src_valid = 1'b0;
    src_last  = 1'b0;
    wait_idle();
    check_log(0);
    check("single_count", bc_v[0], 32'd1);
    check("busy_start_index", 32'(idx_v[0]), 32'h42);
    check("single_done", 32'(done_cnt), 32'd1);
    repeat (4) @(negedge clk);
    check("busy_start_no_rerun", 32'(busy_v[0]), 32'd0);

    // Reset in the middle of an 8-byte image
    load(0, 8'h05);
    push(8'h81, 1'b0);
    push(8'h82, 1'b0);
    src_valid = 1'b0;
    @(negedge clk);
    check("pre_reset_writes", 32'(wr_q.size()), 32'd2);
    reset = 1'b1;
    @(negedge clk);
    check("rst_mid_download", 32'(dl_v[0]), 32'd0);
    check("rst_mid_wr", 32'(wr_v[0]), 32'd0);
    check("rst_mid_busy", 32'(busy_v[0]), 32'd0);
    check("rst_mid_done", 32'(done_v[0]), 32'd0);
    repeat (2) @(negedge clk);
    check("rst_mid_no_done", 32'(done_cnt), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    img   = '{8'hC1, 8'hC2, 8'hC3};
    exp_d = '{8'hC1, 8'hC2, 8'hC3};
    load(0, 8'h06);
    send_image();
    wait_idle();
    check_log(3);
    check("post_reset_count", bc_v[0], 32'd3);

    // WR_GAP=0 with src_valid held high
    img   = '{8'h10, 8'h20, 8'h30};
    exp_d = '{8'h10, 8'h20, 8'h30};
    load(2, 8'h07);
    send_image();
    wait_idle();
    check_log(2);
    check("nogap_count", bc_v[2], 32'd3);
    check("nogap_done", 32'(done_cnt), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
